// File: rtl/uart_cmd_bridge.sv
// Byte bridge between uart_rx and uart_tx: echo (MODE=0) or 2-byte command/response (MODE=1),
// both feeding a TX FIFO drained back-to-back into uart_tx.
module uart_cmd_bridge #(
    parameter int unsigned MODE           = 0,
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Rx_DV,
    input  logic [7:0]                    i_Rx_Byte,
    input  logic                          i_Tx_Done,
    input  logic [8*N_CHANNELS-1:0]       i_Ch_Data,
    input  logic [N_CHANNELS-1:0]         i_Ch_Valid,
    output logic                          o_Tx_DV,
    output logic [7:0]                    o_Tx_Byte,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    output logic                          o_Timeout_Err,
    output logic                          o_Busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {RX_WAIT_CMD, RX_WAIT_ADDR, RX_RESPOND} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT_DONE} tx_state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    rx_state_t     r_rx_state;
    tx_state_t     r_tx_state;
    logic [7:0]    r_cmd;
    logic [7:0]    r_addr;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_resp_b;
    logic          r_push_b;

    logic          w_pop;
    logic          w_push;
    logic [7:0]    w_push_data;
    logic          w_full;
    logic          w_room2;
    logic          w_drop_echo;
    logic [CW-1:0] w_count_nxt;
    logic          w_tx_busy_nxt;
    logic          w_ch_hit;
    logic [7:0]    w_ch_byte;
    logic [7:0]    w_resp_a;
    logic [7:0]    w_resp_b;

    assign w_pop        = (r_tx_state == TX_IDLE) && (r_count != CW'(0));
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_room2      = (r_count <= CW'(FIFO_DEPTH - 2));
    assign w_drop_echo  = (MODE == 0) && i_Rx_DV && w_full && !w_pop;
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign o_Fifo_Count = r_count;

    // Response table, evaluated in the RESPOND cycle so channel data is sampled there.
    always_comb begin
        w_ch_hit  = 1'b0;
        w_ch_byte = 8'h00;
        w_resp_a  = 8'hFE;
        w_resp_b  = r_cmd;
        for (int k = 0; k < int'(N_CHANNELS); k++) begin
            if (r_addr == 8'(k)) begin
                w_ch_hit  = i_Ch_Valid[k];
                w_ch_byte = i_Ch_Data[8*k +: 8];
            end
        end
        if (r_cmd == 8'h02) begin
            w_resp_a = 8'h02;
            w_resp_b = r_addr;
        end else if (r_cmd == 8'h01 && r_addr < 8'(N_CHANNELS)) begin
            w_resp_a = w_ch_hit ? 8'h1D : 8'h1F;
            w_resp_b = w_ch_hit ? w_ch_byte : 8'h00;
        end
    end

    // Push source: raw RX byte in echo mode, response bytes A then B in command mode.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = i_Rx_Byte;
        if (MODE == 0) begin
            w_push = i_Rx_DV && (!w_full || w_pop);
        end else if (r_push_b) begin
            w_push      = 1'b1;
            w_push_data = r_resp_b;
        end else if (r_rx_state == RX_RESPOND && w_room2) begin
            w_push      = 1'b1;
            w_push_data = w_resp_a;
        end
    end

    always_comb begin
        case (r_tx_state)
            TX_IDLE:      w_tx_busy_nxt = w_pop;
            TX_SEND:      w_tx_busy_nxt = 1'b1;
            TX_WAIT_DONE: w_tx_busy_nxt = !i_Tx_Done;
            default:      w_tx_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    // TX FSM: o_Tx_DV is high for the single SEND cycle following the pop.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_tx_state <= TX_IDLE;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Busy     <= 1'b0;
        end else begin
            o_Tx_DV <= 1'b0;
            o_Busy  <= (w_count_nxt != CW'(0)) || w_tx_busy_nxt;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        o_Tx_Byte  <= r_mem[r_rd_ptr];
                        o_Tx_DV    <= 1'b1;
                        r_tx_state <= TX_SEND;
                    end
                end
                TX_SEND:      r_tx_state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (i_Tx_Done) r_tx_state <= TX_IDLE;
                default:      r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX FSM: a byte arriving on the timeout cycle or during RESPOND is still consumed.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_state    <= RX_WAIT_CMD;
            r_cmd         <= 8'h00;
            r_addr        <= 8'h00;
            r_timer       <= '0;
            r_resp_b      <= 8'h00;
            r_push_b      <= 1'b0;
            o_Overflow    <= 1'b0;
            o_Timeout_Err <= 1'b0;
        end else begin
            r_push_b <= 1'b0;
            if (w_drop_echo) o_Overflow <= 1'b1;
            if (MODE != 0) begin
                case (r_rx_state)
                    RX_WAIT_CMD: begin
                        if (i_Rx_DV) begin
                            r_cmd      <= i_Rx_Byte;
                            r_timer    <= '0;
                            r_rx_state <= RX_WAIT_ADDR;
                        end
                    end
                    RX_WAIT_ADDR: begin
                        if (i_Rx_DV) begin
                            r_addr     <= i_Rx_Byte;
                            r_rx_state <= RX_RESPOND;
                        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            o_Timeout_Err <= 1'b1;
                            r_rx_state    <= RX_WAIT_CMD;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    RX_RESPOND: begin
                        if (w_room2) begin
                            r_resp_b <= w_resp_b;
                            r_push_b <= 1'b1;
                        end else begin
                            o_Overflow <= 1'b1;
                        end
                        if (i_Rx_DV) begin
                            r_cmd      <= i_Rx_Byte;
                            r_timer    <= '0;
                            r_rx_state <= RX_WAIT_ADDR;
                        end else begin
                            r_rx_state <= RX_WAIT_CMD;
                        end
                    end
                    default: r_rx_state <= RX_WAIT_CMD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench: an echo instance (FIFO_DEPTH=4) and a command instance (TIMEOUT_CYCLES=100).
module tb_uart_cmd_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        e_rx_dv, e_tx_done, e_tx_dv, e_ovf, e_tmo, e_busy, e_auto;
    logic [7:0]  e_rx_byte, e_tx_byte;
    logic [2:0]  e_count;
    logic [31:0] e_ch_data;
    logic [3:0]  e_ch_valid;

    logic        c_rx_dv, c_tx_done, c_tx_dv, c_ovf, c_tmo, c_busy, c_auto;
    logic [7:0]  c_rx_byte, c_tx_byte;
    logic [3:0]  c_count;
    logic [31:0] c_ch_data;
    logic [3:0]  c_ch_valid;

    logic [7:0] e_q[$];
    logic [7:0] c_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    uart_cmd_bridge #(.MODE(0), .N_CHANNELS(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) u_echo (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(e_rx_dv), .i_Rx_Byte(e_rx_byte),
        .i_Tx_Done(e_tx_done), .i_Ch_Data(e_ch_data), .i_Ch_Valid(e_ch_valid),
        .o_Tx_DV(e_tx_dv), .o_Tx_Byte(e_tx_byte), .o_Fifo_Count(e_count),
        .o_Overflow(e_ovf), .o_Timeout_Err(e_tmo), .o_Busy(e_busy));

    uart_cmd_bridge #(.MODE(1), .N_CHANNELS(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)) u_cmd (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(c_rx_dv), .i_Rx_Byte(c_rx_byte),
        .i_Tx_Done(c_tx_done), .i_Ch_Data(c_ch_data), .i_Ch_Valid(c_ch_valid),
        .o_Tx_DV(c_tx_dv), .o_Tx_Byte(c_tx_byte), .o_Fifo_Count(c_count),
        .o_Overflow(c_ovf), .o_Timeout_Err(c_tmo), .o_Busy(c_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Echo monitor + uart_tx stand-in: compare each DV byte, answer with Tx_Done next cycle.
    initial begin : mon_echo
        logic pend;
        pend = 1'b0;
        e_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) pend = 1'b0;
            else if (e_tx_dv) begin
                pend = 1'b1;
                if (e_q.size() == 0) fail_now($sformatf("e_unexpected byte %0h", e_tx_byte));
                else chk("e_byte", 32'(e_tx_byte), 32'(e_q.pop_front()));
            end
            @(posedge clk);
            #1;
            e_tx_done = pend && e_auto && !rst;
            if (e_tx_done) pend = 1'b0;
        end
    end

    initial begin : mon_cmd
        logic pend;
        pend = 1'b0;
        c_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) pend = 1'b0;
            else if (c_tx_dv) begin
                pend = 1'b1;
                if (c_q.size() == 0) fail_now($sformatf("c_unexpected byte %0h", c_tx_byte));
                else chk("c_byte", 32'(c_tx_byte), 32'(c_q.pop_front()));
            end
            @(posedge clk);
            #1;
            c_tx_done = pend && c_auto && !rst;
            if (c_tx_done) pend = 1'b0;
        end
    end

    task automatic e_send(input logic [7:0] b);
        @(posedge clk); #1;
        e_rx_dv = 1'b1; e_rx_byte = b;
        @(posedge clk); #1;
        e_rx_dv = 1'b0;
    endtask

    task automatic c_send(input logic [7:0] b);
        @(posedge clk); #1;
        c_rx_dv = 1'b1; c_rx_byte = b;
        @(posedge clk); #1;
        c_rx_dv = 1'b0;
    endtask

    task automatic c_req(input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [7:0] ea, input logic [7:0] eb);
        c_q.push_back(ea);
        c_q.push_back(eb);
        c_send(cmd);
        c_send(addr);
        repeat (10) @(posedge clk);
    endtask

    task automatic e_drain(input string name);
        int t = 0;
        while ((e_q.size() != 0 || e_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now({name, " drain timeout"});
    endtask

    task automatic c_drain(input string name);
        int t = 0;
        while ((c_q.size() != 0 || c_busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now({name, " drain timeout"});
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1;
        e_rx_dv = 1'b0; e_rx_byte = 8'h00; e_ch_data = 32'h0; e_ch_valid = 4'h0; e_auto = 1'b1;
        c_rx_dv = 1'b0; c_rx_byte = 8'h00; c_auto = 1'b1;
        c_ch_data = 32'h0037_0000; c_ch_valid = 4'b0100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e_dv", 32'(e_tx_dv), 0);
        chk("rst_e_count", 32'(e_count), 0);
        chk("rst_e_busy", 32'(e_busy), 0);
        chk("rst_c_flags", {30'h0, c_ovf, c_tmo}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Echo, idle TX: DV exactly 2 cycles after the RX strobe.
        e_q.push_back(8'h41);
        e_send(8'h41);
        @(negedge clk);
        chk("e_lat1_dv", 32'(e_tx_dv), 0);
        @(negedge clk);
        chk("e_lat2_dv", 32'(e_tx_dv), 1);
        e_drain("e_single");
        chk("e_single_busy", 32'(e_busy), 0);

        // Echo burst with Tx_Done withheld: one in flight, four queued, last dropped.
        e_auto = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) e_q.push_back(8'(8'h10 + i));
            e_send(8'(8'h10 + i));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("e_burst_count", 32'(e_count), 4);
        chk("e_burst_ovf", 32'(e_ovf), 1);
        chk("e_burst_busy", 32'(e_busy), 1);
        e_auto = 1'b1;
        e_drain("e_burst");
        chk("e_burst_count_end", 32'(e_count), 0);

        // Command mode response table.
        c_req(8'h01, 8'h02, 8'h1D, 8'h37);
        c_req(8'h01, 8'h01, 8'h1F, 8'h00);
        c_req(8'h01, 8'h07, 8'hFE, 8'h01);
        c_req(8'h55, 8'h00, 8'hFE, 8'h55);
        c_req(8'h02, 8'h9A, 8'h02, 8'h9A);
        c_drain("c_table");
        chk("c_table_ovf", 32'(c_ovf), 0);

        // Address byte lands on the last counter value (99): frame completes.
        c_q.push_back(8'h1D);
        c_q.push_back(8'h37);
        c_send(8'h01);
        repeat (98) @(posedge clk);
        c_send(8'h02);
        c_drain("c_edge99");
        chk("c_edge99_tmo", 32'(c_tmo), 0);

        // One cycle later: frame abandoned, following bytes form a new ping request.
        c_q.push_back(8'h02);
        c_q.push_back(8'h03);
        c_send(8'h01);
        repeat (99) @(posedge clk);
        c_send(8'h02);
        c_send(8'h03);
        c_drain("c_timeout");
        chk("c_timeout_tmo", 32'(c_tmo), 1);

        // Reset in WAIT_ADDR with three bytes queued and one in flight.
        c_auto = 1'b0;
        c_q.push_back(8'h02);
        c_send(8'h02);
        c_send(8'h11);
        c_send(8'h02);
        c_send(8'h22);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("c_pre_rst_count", 32'(c_count), 3);
        c_send(8'h01);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("c_rst_dv", 32'(c_tx_dv), 0);
        chk("c_rst_count", 32'(c_count), 0);
        chk("c_rst_flags", {30'h0, c_ovf, c_tmo}, 0);
        chk("c_rst_busy", 32'(c_busy), 0);
        chk("e_rst_ovf", 32'(e_ovf), 0);
        chk("c_rst_q_consumed", 32'(c_q.size()), 0);
        c_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        c_auto = 1'b1;
        c_req(8'h02, 8'h5A, 8'h02, 8'h5A);
        c_req(8'h01, 8'h02, 8'h1D, 8'h37);
        c_drain("c_post_rst");
        chk("c_post_rst_flags", {30'h0, c_ovf, c_tmo}, 0);
        chk("e_tmo_never", 32'(e_tmo), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
